// File: rtl/elevator_controller.sv
// Single-car SCAN dispatcher: serves latched cabin/hall requests, drives car
// motion and door, and strobes per-floor clears back to the button latch stage.
//
// state     | meaning
// IDLE      | car parked, choosing next action from pending requests
// MOVE_UP   | travelling up one floor per TRAVEL_CYCLES
// MOVE_DOWN | travelling down one floor per TRAVEL_CYCLES
// DOOR      | door open for DOOR_CYCLES, clearing served requests

module elevator_controller #(
  parameter int FLOORS        = 8,
  parameter int TRAVEL_CYCLES = 16,
  parameter int DOOR_CYCLES   = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [FLOORS-1:0]          active_in_levels,
  input  logic [FLOORS-1:0]          active_out_up_levels,
  input  logic [FLOORS-1:0]          active_out_down_levels,
  output logic [FLOORS-1:0]          inactivate_in_levels,
  output logic [FLOORS-1:0]          inactivate_out_up_levels,
  output logic [FLOORS-1:0]          inactivate_out_down_levels,
  output logic [$clog2(FLOORS)-1:0]  current_floor,
  output logic                       motor_up,
  output logic                       motor_down,
  output logic                       door_open,
  output logic                       dir_up
);

  localparam int FLOOR_W  = $clog2(FLOORS);
  localparam int TRAVEL_W = (TRAVEL_CYCLES > 1) ? $clog2(TRAVEL_CYCLES) : 1;
  localparam int DOOR_W   = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
  localparam logic [TRAVEL_W-1:0] TRAVEL_LAST = TRAVEL_W'(TRAVEL_CYCLES - 1);
  localparam logic [DOOR_W-1:0]   DOOR_LAST   = DOOR_W'(DOOR_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, MOVE_UP, MOVE_DOWN, DOOR} state_t;

  state_t              state;
  logic [TRAVEL_W-1:0] travel_cnt;
  logic [DOOR_W-1:0]   door_cnt;

  function automatic logic [FLOORS-1:0] above_mask(input logic [FLOOR_W-1:0] f);
    above_mask = '0;
    for (int i = 0; i < FLOORS; i++) above_mask[i] = (i > int'(f));
  endfunction

  function automatic logic [FLOORS-1:0] below_mask(input logic [FLOOR_W-1:0] f);
    below_mask = '0;
    for (int i = 0; i < FLOORS; i++) below_mask[i] = (i < int'(f));
  endfunction

  function automatic logic [FLOORS-1:0] onehot(input logic [FLOOR_W-1:0] f);
    onehot = '0;
    for (int i = 0; i < FLOORS; i++) onehot[i] = (i == int'(f));
  endfunction

  logic [FLOORS-1:0]  req;
  logic               above, below, here;
  logic               idle_dir;
  logic [FLOOR_W-1:0] floor_next_up, floor_next_down;
  logic               up_stop, up_ahead, up_flip;
  logic               down_stop, down_ahead, down_flip;

  always_comb begin
    req   = active_in_levels | active_out_up_levels | active_out_down_levels;
    above = |(req & above_mask(current_floor));
    below = |(req & below_mask(current_floor));
    here  = req[current_floor];

    // Keep direction if this floor's call agrees with it, else take the pending hall direction.
    if (active_in_levels[current_floor] ||
        (dir_up ? active_out_up_levels[current_floor] : active_out_down_levels[current_floor]))
      idle_dir = dir_up;
    else
      idle_dir = active_out_up_levels[current_floor];

    floor_next_up   = current_floor + FLOOR_W'(1);
    floor_next_down = current_floor - FLOOR_W'(1);

    up_ahead  = |(req & above_mask(floor_next_up));
    up_flip   = !active_in_levels[floor_next_up] && !active_out_up_levels[floor_next_up];
    up_stop   = active_in_levels[floor_next_up] || active_out_up_levels[floor_next_up] ||
                (active_out_down_levels[floor_next_up] && !up_ahead);

    down_ahead = |(req & below_mask(floor_next_down));
    down_flip  = !active_in_levels[floor_next_down] && !active_out_down_levels[floor_next_down];
    down_stop  = active_in_levels[floor_next_down] || active_out_down_levels[floor_next_down] ||
                 (active_out_up_levels[floor_next_down] && !down_ahead);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state                      <= IDLE;
      current_floor              <= '0;
      dir_up                     <= 1'b1;
      motor_up                   <= 1'b0;
      motor_down                 <= 1'b0;
      door_open                  <= 1'b0;
      inactivate_in_levels       <= '0;
      inactivate_out_up_levels   <= '0;
      inactivate_out_down_levels <= '0;
      travel_cnt                 <= '0;
      door_cnt                   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (here) begin
            state                      <= DOOR;
            door_open                  <= 1'b1;
            door_cnt                   <= '0;
            dir_up                     <= idle_dir;
            inactivate_in_levels       <= onehot(current_floor);
            inactivate_out_up_levels   <= idle_dir ? onehot(current_floor) : '0;
            inactivate_out_down_levels <= idle_dir ? '0 : onehot(current_floor);
          end else if (above && (dir_up || !below)) begin
            state      <= MOVE_UP;
            dir_up     <= 1'b1;
            motor_up   <= 1'b1;
            travel_cnt <= '0;
          end else if (below) begin
            state      <= MOVE_DOWN;
            dir_up     <= 1'b0;
            motor_down <= 1'b1;
            travel_cnt <= '0;
          end
        end

        MOVE_UP: begin
          if (travel_cnt == TRAVEL_LAST) begin
            travel_cnt    <= '0;
            current_floor <= floor_next_up;
            if (up_stop) begin
              state                      <= DOOR;
              motor_up                   <= 1'b0;
              door_open                  <= 1'b1;
              door_cnt                   <= '0;
              dir_up                     <= !up_flip;
              inactivate_in_levels       <= onehot(floor_next_up);
              inactivate_out_up_levels   <= up_flip ? '0 : onehot(floor_next_up);
              inactivate_out_down_levels <= up_flip ? onehot(floor_next_up) : '0;
            end else if (!up_ahead) begin
              state    <= IDLE;
              motor_up <= 1'b0;
            end
          end else begin
            travel_cnt <= travel_cnt + TRAVEL_W'(1);
          end
        end

        MOVE_DOWN: begin
          if (travel_cnt == TRAVEL_LAST) begin
            travel_cnt    <= '0;
            current_floor <= floor_next_down;
            if (down_stop) begin
              state                      <= DOOR;
              motor_down                 <= 1'b0;
              door_open                  <= 1'b1;
              door_cnt                   <= '0;
              dir_up                     <= down_flip;
              inactivate_in_levels       <= onehot(floor_next_down);
              inactivate_out_up_levels   <= down_flip ? onehot(floor_next_down) : '0;
              inactivate_out_down_levels <= down_flip ? '0 : onehot(floor_next_down);
            end else if (!down_ahead) begin
              state      <= IDLE;
              motor_down <= 1'b0;
            end
          end else begin
            travel_cnt <= travel_cnt + TRAVEL_W'(1);
          end
        end

        DOOR: begin
          if (door_cnt == DOOR_LAST) begin
            state                      <= IDLE;
            door_open                  <= 1'b0;
            door_cnt                   <= '0;
            inactivate_in_levels       <= '0;
            inactivate_out_up_levels   <= '0;
            inactivate_out_down_levels <= '0;
          end else begin
            door_cnt <= door_cnt + DOOR_W'(1);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_elevator_controller.sv
// Bench for elevator_controller: emulates the button latch stage and predicts
// each door opening (floor, cycle, direction, clears) from a SCAN service model.

module tb_elevator_controller;

  localparam int NF = 8;
  localparam int TC = 4;
  localparam int DC = 6;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [NF-1:0] req_in = '0, req_up = '0, req_dn = '0;
  logic [NF-1:0] inact_in, inact_up, inact_dn;
  logic [2:0]    current_floor;
  logic          motor_up, motor_down, door_open, dir_up;

  always #5 clk = ~clk;

  elevator_controller #(.FLOORS(NF), .TRAVEL_CYCLES(TC), .DOOR_CYCLES(DC)) dut (
    .clk                        (clk),
    .reset                      (reset),
    .active_in_levels           (req_in),
    .active_out_up_levels       (req_up),
    .active_out_down_levels     (req_dn),
    .inactivate_in_levels       (inact_in),
    .inactivate_out_up_levels   (inact_up),
    .inactivate_out_down_levels (inact_dn),
    .current_floor              (current_floor),
    .motor_up                   (motor_up),
    .motor_down                 (motor_down),
    .door_open                  (door_open),
    .dir_up                     (dir_up)
  );

  typedef struct {
    int             floor;
    int             cyc;
    bit             dir;
    logic [3*NF-1:0] inact;
  } ev_t;

  ev_t           exp_q[$];
  int            n_pass = 0, n_total = 0;
  int            cyc = 0, motor_cycles = 0, door_cycles = 0, m_travel = 0;
  logic          prev_door = 1'b0;
  int            mpos = 0;
  bit            mdir = 1'b1;
  logic [NF-1:0] mi = '0, mu = '0, md = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %0h, expected %0h", tag, obs, expv);
  endtask

  function automatic bit any_in(input logic [NF-1:0] v, input int lo, input int hi);
    for (int i = lo; i <= hi; i++) if (v[i]) return 1'b1;
    return 1'b0;
  endfunction

  // Record a service at the model's floor and drop the requests it clears.
  task automatic push_ev(input int t);
    ev_t e;
    logic [NF-1:0] oh;
    oh = '0;
    oh[mpos] = 1'b1;
    e.floor = mpos;
    e.cyc   = t;
    e.dir   = mdir;
    e.inact = {oh, mdir ? oh : {NF{1'b0}}, mdir ? {NF{1'b0}} : oh};
    exp_q.push_back(e);
    mi[mpos] = 1'b0;
    if (mdir) mu[mpos] = 1'b0;
    else      md[mpos] = 1'b0;
  endtask

  // Walk the whole service order for a static request set; t is the cycle of the next idle decision.
  task automatic model_run(input int t0);
    int t, f;
    logic [NF-1:0] r;
    t = t0;
    while ((mi | mu | md) != '0) begin
      r = mi | mu | md;
      if (r[mpos]) begin
        if (!(mi[mpos] || (mdir ? mu[mpos] : md[mpos]))) mdir = mu[mpos];
        push_ev(t);
        t += DC + 1;
      end else if (any_in(r, mpos + 1, NF - 1) && (mdir || !any_in(r, 0, mpos - 1))) begin
        mdir = 1'b1;
        f = mpos + 1;
        while (!(mi[f] || mu[f] || (md[f] && !any_in(r, f + 1, NF - 1)))) f++;
        if (!mi[f] && !mu[f]) mdir = 1'b0;
        m_travel += (f - mpos) * TC;
        t += (f - mpos) * TC;
        mpos = f;
        push_ev(t);
        t += DC + 1;
      end else begin
        mdir = 1'b0;
        f = mpos - 1;
        while (!(mi[f] || md[f] || (mu[f] && !any_in(r, 0, f - 1)))) f--;
        if (!mi[f] && !md[f]) mdir = 1'b1;
        m_travel += (mpos - f) * TC;
        t += (mpos - f) * TC;
        mpos = f;
        push_ev(t);
        t += DC + 1;
      end
    end
  endtask

  task automatic tick();
    ev_t e;
    @(posedge clk);
    #1;
    cyc++;
    if (motor_up || motor_down) motor_cycles++;
    if (door_open) door_cycles++;
    if (door_open && !prev_door) begin
      check("door_expected", 32'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("door_floor", 32'(current_floor), e.floor);
        check("door_cycle", cyc, e.cyc);
        check("door_dir", 32'(dir_up), 32'(e.dir));
        check("door_clears", 32'({inact_in, inact_up, inact_dn}), 32'(e.inact));
        check("door_motor_off", {motor_up, motor_down}, 0);
      end
    end
    prev_door = door_open;
    req_in = req_in & ~inact_in;
    req_up = req_up & ~inact_up;
    req_dn = req_dn & ~inact_dn;
  endtask

  task automatic run_batch(input logic [NF-1:0] vin, input logic [NF-1:0] vup, input logic [NF-1:0] vdn);
    int guard, ne;
    req_in |= vin;
    req_up |= vup;
    req_dn |= vdn;
    mi = req_in;
    mu = req_up;
    md = req_dn;
    motor_cycles = 0;
    door_cycles  = 0;
    m_travel     = 0;
    model_run(cyc + 1);
    ne = exp_q.size();
    guard = 0;
    while ((exp_q.size() > 0 || door_open) && guard < 3000) begin
      tick();
      guard++;
    end
    repeat (3) tick();
    check("events_done", exp_q.size(), 0);
    exp_q.delete();
    check("travel_cycles", motor_cycles, m_travel);
    check("door_cycles", door_cycles, ne * DC);
    check("final_floor", 32'(current_floor), mpos);
    check("requests_cleared", 32'({req_in, req_up, req_dn}), 0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    req_in = '0;
    req_up = '0;
    req_dn = '0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    mpos = 0;
    mdir = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held with random requests pending
    req_in = NF'($urandom);
    req_up = NF'($urandom);
    req_dn = NF'($urandom);
    tick();
    tick();
    check("rst_floor", 32'(current_floor), 0);
    check("rst_dir", 32'(dir_up), 1);
    check("rst_motion", {motor_up, motor_down, door_open}, 0);
    check("rst_clears", 32'({inact_in, inact_up, inact_dn}), 0);
    req_in = '0;
    req_up = '0;
    req_dn = '0;
    reset = 1'b1;
    tick();

    // Cabin call three floors up, then opposing calls from floor 3
    run_batch(8'b0000_1000, '0, '0);
    run_batch(8'b0010_0010, '0, '0);
    // Reach floor 2, then a hall-up call at the car's floor
    run_batch(8'b0000_0100, '0, '0);
    run_batch('0, 8'b0000_0100, '0);

    // Passing a hall-down call, then stopping for a hall-up call
    do_reset();
    run_batch(8'b0100_0000, '0, 8'b0001_0000);
    do_reset();
    run_batch(8'b0100_0000, 8'b0001_0000, '0);

    // Same-floor opposite calls and a top-floor down call
    run_batch(8'b0000_0001, 8'b0001_0000, 8'b1001_0000);

    for (int b = 0; b < 8; b++) begin
      run_batch(NF'($urandom) & NF'($urandom), NF'($urandom) & NF'($urandom),
                NF'($urandom) & NF'($urandom));
    end

    // Reset in the middle of travel between floors 2 and 3
    do_reset();
    req_in = 8'b1000_0000;
    repeat (10) tick();
    check("mid_floor", 32'(current_floor), 2);
    check("mid_motor", 32'(motor_up), 1);
    reset = 1'b0;
    req_in = '0;
    tick();
    check("abort_floor", 32'(current_floor), 0);
    check("abort_motion", {motor_up, motor_down, door_open}, 0);
    check("abort_dir", 32'(dir_up), 1);
    reset = 1'b1;
    mpos = 0;
    mdir = 1'b1;
    motor_cycles = 0;
    door_cycles  = 0;
    repeat (20) tick();
    check("abort_stays_idle", motor_cycles + door_cycles, 0);
    run_batch(8'b0000_0010, '0, '0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/elevator_controller.md
Name: elevator_controller

Overview:
- Single-car SCAN dispatcher directly downstream of the button latch stage.
- Consumes the latched request vectors (cabin, hall-up, hall-down) and drives car position, motor and door.
- Returns per-floor inactivate vectors to the latch stage so that served requests are cleared.

Parameters:
FLOORS, 8, number of floors; must equal the button stage BUTTONS_WIDTH; >= 2
TRAVEL_CYCLES, 16, clock cycles to move one floor; >= 1
DOOR_CYCLES, 32, clock cycles the door stays open per stop; >= 1
(localparam FLOOR_W = $clog2(FLOORS); counter widths derived from TRAVEL_CYCLES/DOOR_CYCLES via $clog2)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  reset, synchronous, active-low
active_in_levels  in  FLOORS  latched cabin requests, bit i = floor i
active_out_up_levels  in  FLOORS  latched hall-up requests
active_out_down_levels  in  FLOORS  latched hall-down requests
inactivate_in_levels  out  FLOORS  clear strobe for cabin requests
inactivate_out_up_levels  out  FLOORS  clear strobe for hall-up requests
inactivate_out_down_levels  out  FLOORS  clear strobe for hall-down requests
current_floor  out  FLOOR_W  car position
motor_up  out  1  car travelling up
motor_down  out  1  car travelling down
door_open  out  1  door open
dir_up  out  1  sweep direction: 1 = up, 0 = down

Behaviour:
- All outputs registered. Reset (reset==0 at clk edge) gives: state IDLE, current_floor=0, dir_up=1, all other outputs 0, timers 0. Reset overrides any state, including mid-travel and door-open.
- Derived signals:
  - req = in|up|down.
  - above = |(req & ~((2<<current_floor)-1)).
  - below = |(req & ((1<<current_floor)-1)).
  - here = req[current_floor].
- States: IDLE, MOVE_UP, MOVE_DOWN, DOOR.
- IDLE:
  - If here, go to DOOR.
  - Else if above and (dir_up or !below), go to MOVE_UP and set dir_up=1.
  - Else if below, go to MOVE_DOWN and set dir_up=0.
  - Else stay. Outputs are 0 apart from current_floor/dir_up.
- MOVE_UP/MOVE_DOWN:
  - motor_up (or motor_down) = 1 for the whole state.
  - The travel timer counts 0..TRAVEL_CYCLES-1. At terminal count, current_floor is incremented (or decremented) and the timer is cleared.
  - The arrival decision is made on that same edge, using the new floor f and the current request vectors.
  - MOVE_UP stops if in[f] | up[f] | (down[f] & no requests above f). MOVE_DOWN is the mirror: in[f] | down[f] | (up[f] & no requests below f).
  - On a stop, go to DOOR. If the stop was only for the opposite-direction hall call, flip dir_up.
  - With no stop: continue if requests remain ahead; otherwise go to IDLE.
  - Requests latched during travel are considered at the next arrival.
  - The floor never leaves 0..FLOORS-1, because travel starts only when a request lies ahead.
- DOOR:
  - door_open=1 and motors 0. The door timer counts 0..DOOR_CYCLES-1, then the state goes to IDLE.
  - Every DOOR cycle, inactivate_in_levels = onehot(current_floor).
  - inactivate_out_up_levels = onehot(current_floor) if dir_up, else 0. inactivate_out_down_levels = onehot(current_floor) if !dir_up, else 0.
  - All inactivate outputs are 0 outside DOOR.
  - A button still held during DOOR wins in the latch stage. The door timer does not restart on such presses.
- Entry to DOOR from IDLE via here:
  - dir_up is kept if the request at this floor matches the direction (in, or the same-direction hall call).
  - Otherwise dir_up flips to the pending hall direction.
  - The opposite hall call at the same floor is served by a second DOOR cycle after IDLE.
- Simultaneous events: an arrival and a new request at the arrival floor in the same cycle count as a stop. With requests both above and below in IDLE, the current dir_up wins.

Test Plan:
1. Hold reset=0 for 2 cycles with random requests → current_floor=0, dir_up=1, motor/door/inactivate all 0.
2. TRAVEL_CYCLES=4, DOOR_CYCLES=6, floor 0 idle, in=8'b0000_1000 → motor_up for 12 cycles, current_floor 1,2,3 at 4-cycle spacing, then door_open for 6 cycles with inactivate_in_levels=8'b0000_1000, then IDLE.
3. Idle at floor 3 with dir_up=1, in[5] and in[1] set in the same cycle → car serves 5 first (door at floor 5), then travels down and serves 1; dir_up=0 at floor 1.
4. Moving up from floor 0 to in[6] with down[4] latched → no stop at 4. Repeat with up[4] → stop at 4 and inactivate_out_up_levels=8'b0001_0000 during the door.
5. Idle at floor 2 with up[2] set → door_open asserted next cycle, no motor activity, inactivate_out_up_levels=8'b0000_0100.
6. Assert reset=0 mid-travel between floors 2 and 3 → on next cycle current_floor=0, motor_up=0, state IDLE; the car resumes only after a new request.
